rgmii_tx_framer: RTL and testbench

- Gigabit RGMII transmit framer.
- Accepts a byte stream from the MAC/switch egress queue using a valid/ready handshake.
- Builds the wire frame: preamble, SFD, payload, optional pad, CRC32 FCS and inter-frame gap.
- Emits one byte per clock as packed DDR pairs that drive ddr_output_buffer instances directly: 8-bit data instance with SWAP_ENABLE=1; 1-bit control instance with SWAP_ENABLE=1.

---
 rtl/rgmii_tx_framer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_tx_framer.sv
// Gigabit RGMII transmit framer: wraps a valid/ready byte stream into preamble, SFD, payload, FCS and IFG.
// Define RGMII_TX_PAD_EN to zero-pad frames shorter than MIN_FRAME_BYTES before the FCS.
module rgmii_tx_framer #(
   parameter int PREAMBLE_BYTES  = 7,
   parameter int IFG_BYTES       = 12
`ifdef RGMII_TX_PAD_EN
   ,
   parameter int MIN_FRAME_BYTES = 60
`endif
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] txd_ddr,
   output logic [1:0] tx_ctl_ddr,
   output logic       busy,
   output logic       underrun
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_SFD      = 3'd2,
      S_DATA     = 3'd3,
      S_FCS      = 3'd4,
      S_DRAIN    = 3'd5,
      S_IFG      = 3'd6
`ifdef RGMII_TX_PAD_EN
      ,
      S_PAD      = 3'd7
`endif
   } state_t;

   localparam logic [15:0] LP_PRE_LAST = 16'(PREAMBLE_BYTES - 1);
   localparam logic [15:0] LP_IFG_LAST = 16'(IFG_BYTES - 1);
   localparam logic [15:0] LP_FCS_LAST = 16'd3;
   localparam logic [15:0] LP_CNT_MAX  = 16'hFFFF;
`ifdef RGMII_TX_PAD_EN
   localparam logic [15:0] LP_MIN_LEN  = 16'(MIN_FRAME_BYTES);
`endif
   localparam logic [31:0] LP_CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] LP_CRC_POLY = 32'hEDB8_8320;
   localparam logic [7:0]  LP_PRE_BYTE = 8'h55;
   localparam logic [7:0]  LP_SFD_BYTE = 8'hD5;
   localparam logic [1:0]  LP_CTL_IDLE = 2'b00;
   localparam logic [1:0]  LP_CTL_DATA = 2'b11;
   localparam logic [1:0]  LP_CTL_ERR  = 2'b01;

   // Reflected IEEE 802.3 CRC32, one byte, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data_in);
      logic [31:0] c;
      c = crc_in;
      for (int b = 0; b < 8; b++) begin
         if (c[0] ^ data_in[b]) begin
            c = (c >> 1) ^ LP_CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_seq;
   logic [15:0] w_seq_next;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_inc;
   logic [15:0] w_cnt_next;
   logic [31:0] r_crc;
   logic [31:0] w_crc_next;
   logic [31:0] w_crc_data;
   logic [31:0] w_fcs;
   logic        w_pad_needed;
   logic [7:0]  w_txd;
   logic [1:0]  w_ctl;
   logic        w_underrun;
   logic [7:0]  r_txd;
   logic [1:0]  r_ctl;
   logic        r_busy;
   logic        r_underrun;

   assign w_cnt_inc  = (r_cnt == LP_CNT_MAX) ? r_cnt : (r_cnt + 16'd1);
   assign w_crc_data = crc32_byte(r_crc, tx_data);
   assign w_fcs      = ~r_crc;
`ifdef RGMII_TX_PAD_EN
   assign w_pad_needed = (w_cnt_inc < LP_MIN_LEN);
`else
   assign w_pad_needed = 1'b0;
`endif

   assign tx_ready   = (r_state == S_DATA) || (r_state == S_DRAIN);
   assign txd_ddr    = r_txd;
   assign tx_ctl_ddr = r_ctl;
   assign busy       = r_busy;
   assign underrun   = r_underrun;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (tx_valid) begin
               w_state_next = S_PREAMBLE;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_PREAMBLE: begin
            if (r_seq == LP_PRE_LAST) begin
               w_state_next = S_SFD;
            end else begin
               w_state_next = S_PREAMBLE;
            end
         end
         S_SFD: begin
            w_state_next = S_DATA;
         end
         S_DATA: begin
            if (tx_valid) begin
               if (tx_last) begin
`ifdef RGMII_TX_PAD_EN
                  w_state_next = w_pad_needed ? S_PAD : S_FCS;
`else
                  w_state_next = S_FCS;
`endif
               end else begin
                  w_state_next = S_DATA;
               end
            end else begin
               w_state_next = tx_last ? S_IFG : S_DRAIN;
            end
         end
`ifdef RGMII_TX_PAD_EN
         S_PAD: begin
            if (w_cnt_inc >= LP_MIN_LEN) begin
               w_state_next = S_FCS;
            end else begin
               w_state_next = S_PAD;
            end
         end
`endif
         S_FCS: begin
            if (r_seq == LP_FCS_LAST) begin
               w_state_next = S_IFG;
            end else begin
               w_state_next = S_FCS;
            end
         end
         S_DRAIN: begin
            if (tx_valid && tx_last) begin
               w_state_next = S_IFG;
            end else begin
               w_state_next = S_DRAIN;
            end
         end
         S_IFG: begin
            if (r_seq == LP_IFG_LAST) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_IFG;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Wire byte, CRC and length decisions for the current state.
   always_comb begin
      w_txd      = 8'h00;
      w_ctl      = LP_CTL_IDLE;
      w_underrun = 1'b0;
      w_crc_next = r_crc;
      w_cnt_next = r_cnt;
      case (r_state)
         S_PREAMBLE: begin
            w_txd = LP_PRE_BYTE;
            w_ctl = LP_CTL_DATA;
         end
         S_SFD: begin
            w_txd = LP_SFD_BYTE;
            w_ctl = LP_CTL_DATA;
         end
         S_DATA: begin
            if (tx_valid) begin
               w_txd      = tx_data;
               w_ctl      = LP_CTL_DATA;
               w_crc_next = w_crc_data;
               w_cnt_next = w_cnt_inc;
            end else begin
               w_txd      = 8'h00;
               w_ctl      = LP_CTL_ERR;
               w_underrun = 1'b1;
            end
         end
`ifdef RGMII_TX_PAD_EN
         S_PAD: begin
            w_txd      = 8'h00;
            w_ctl      = LP_CTL_DATA;
            w_crc_next = crc32_byte(r_crc, 8'h00);
            w_cnt_next = w_cnt_inc;
         end
`endif
         S_FCS: begin
            w_ctl = LP_CTL_DATA;
            case (r_seq[1:0])
               2'd0:    w_txd = w_fcs[7:0];
               2'd1:    w_txd = w_fcs[15:8];
               2'd2:    w_txd = w_fcs[23:16];
               default: w_txd = w_fcs[31:24];
            endcase
         end
         S_IFG: begin
            // Fresh CRC and length for the next frame; aborted frames leave them dirty until here.
            if (w_state_next == S_IDLE) begin
               w_crc_next = LP_CRC_INIT;
               w_cnt_next = 16'd0;
            end else begin
               w_crc_next = r_crc;
               w_cnt_next = r_cnt;
            end
         end
         default: begin
            w_txd = 8'h00;
            w_ctl = LP_CTL_IDLE;
         end
      endcase
   end

   // Per-state sequence counter: restarts on every state change.
   always_comb begin
      if (w_state_next != r_state) begin
         w_seq_next = 16'd0;
      end else if (r_seq == LP_CNT_MAX) begin
         w_seq_next = r_seq;
      end else begin
         w_seq_next = r_seq + 16'd1;
      end
   end

   // Datapath registers and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_seq      <= 16'd0;
         r_cnt      <= 16'd0;
         r_crc      <= LP_CRC_INIT;
         r_txd      <= 8'h00;
         r_ctl      <= LP_CTL_IDLE;
         r_busy     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_seq      <= w_seq_next;
         r_cnt      <= w_cnt_next;
         r_crc      <= w_crc_next;
         r_txd      <= w_txd;
         r_ctl      <= w_ctl;
         r_busy     <= (w_state_next != S_IDLE);
         r_underrun <= w_underrun;
      end
   end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Directed bench for rgmii_tx_framer: frame content, FCS, gap, underrun, async reset and single-byte frames.
`timescale 1ns/1ps
module tb_rgmii_tx_framer;
`ifdef RGMII_TX_PAD_EN
   localparam bit PAD_ON = 1'b1;
`else
   localparam bit PAD_ON = 1'b0;
`endif
   localparam int PRE_N = 7;
   localparam int MIN_N = 60;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready;
   logic [7:0] txd_ddr;
   logic [1:0] tx_ctl_ddr;
   logic       busy;
   logic       underrun;

   int checks = 0;
   int failures = 0;
   logic [10:0] mon_q[$];
   int ur_count = 0;
   int rdy_count = 0;
   logic [7:0] pay [0:1][0:127];

   always #4 clock = ~clock;

   rgmii_tx_framer dut (
      .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_last(tx_last), .tx_ready(tx_ready), .txd_ddr(txd_ddr), .tx_ctl_ddr(tx_ctl_ddr),
      .busy(busy), .underrun(underrun)
   );

   // Wire monitor: one {busy, ctl, data} entry per clock, sampled on the falling edge.
   always @(negedge clock) begin
      mon_q.push_back({busy, tx_ctl_ddr, txd_ddr});
      if (underrun) ur_count++;
      if (tx_ready) rdy_count++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h000000, b};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic send(input int slot, input int n, input int gap_at, input int abort_at);
      int i = 0;
      int cyc = 0;
      bit gapped = 1'b0;
      bit aborted = 1'b0;
      while (i < n && cyc < 2000 && !aborted) begin
         @(negedge clock);
         cyc++;
         if (abort_at >= 0 && i == abort_at) begin
            aborted = 1'b1;
         end else if (gap_at >= 0 && i == gap_at && !gapped && tx_ready) begin
            tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00; gapped = 1'b1;
         end else begin
            tx_valid = 1'b1; tx_data = pay[slot][i]; tx_last = (i == n - 1);
            if (tx_ready) i++;
         end
      end
      if (!aborted) chk("send accepted", 32'(i), 32'(n));
   endtask

   task automatic idle_inputs();
      @(negedge clock);
      tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
   endtask

   // trunc>=0: frame cut by an underrun after trunc bytes; hand=1: use the given FCS instead of the model.
   task automatic check_frame(input string tag, input int slot, input int n, input int trunc,
                              input bit hand, input logic [31:0] fcs_hand,
                              input int from, output int st, output int last);
      logic [9:0] exp_q[$];
      logic [31:0] crc;
      int body;
      crc = 32'hFFFFFFFF;
      for (int k = 0; k < PRE_N; k++) exp_q.push_back({2'b11, 8'h55});
      exp_q.push_back({2'b11, 8'hD5});
      if (trunc >= 0) begin
         for (int k = 0; k < trunc; k++) exp_q.push_back({2'b11, pay[slot][k]});
         exp_q.push_back({2'b01, 8'h00});
      end else begin
         body = (PAD_ON && n < MIN_N) ? MIN_N : n;
         for (int k = 0; k < body; k++) begin
            logic [7:0] b;
            b = (k < n) ? pay[slot][k] : 8'h00;
            exp_q.push_back({2'b11, b});
            crc = crc_step(crc, b);
         end
         crc = hand ? fcs_hand : ~crc;
         for (int k = 0; k < 4; k++) exp_q.push_back({2'b11, crc[8*k +: 8]});
      end
      st = -1;
      for (int i = from; i < mon_q.size(); i++) begin
         if (mon_q[i][9:8] != 2'b00) begin
            st = i;
            break;
         end
      end
      chk({tag, " found"}, 32'(st >= 0), 32'd1);
      if (st < 0) begin
         st = from;
         last = from;
      end else begin
         last = st + exp_q.size() - 1;
         chk({tag, " length"}, 32'(mon_q.size() > last), 32'd1);
         for (int j = 0; j < exp_q.size() && st + j < mon_q.size(); j++) begin
            chk($sformatf("%s byte%0d", tag, j), 32'(mon_q[st+j][9:0]), 32'(exp_q[j]));
            if (mon_q[st+j][9:0] !== exp_q[j]) break;
         end
      end
   endtask

   task automatic check_idle(input string tag, input int from, input int n);
      for (int k = 0; k < n; k++) begin
         if (from + k >= mon_q.size()) begin
            chk($sformatf("%s missing%0d", tag, k), 32'(from + k), 32'(mon_q.size() - 1));
            break;
         end
         chk($sformatf("%s idle%0d", tag, k), 32'(mon_q[from+k][9:0]), 32'd0);
         if (mon_q[from+k][9:0] !== 10'd0) break;
      end
   endtask

   initial begin
      int mk, st, lst, st2, lst2, u0, r0;
      #1 reset_n = 1'b0;
      #9;
      chk("rst txd", 32'(txd_ddr), 32'd0);
      chk("rst ctl", 32'(tx_ctl_ddr), 32'd0);
      chk("rst ready", 32'(tx_ready), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst underrun", 32'(underrun), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      chk("idle ready", 32'(tx_ready), 32'd0);

      // "123456789": FCS 0xCBF43926 (pad off)
      for (int k = 0; k < 9; k++) pay[0][k] = 8'h31 + 8'(k);
      mk = mon_q.size();
      send(0, 9, -1, -1);
      idle_inputs();
      repeat (100) @(posedge clock);
      check_frame("crc9", 0, 9, -1, !PAD_ON, 32'hCBF43926, mk, st, lst);
      check_idle("crc9 ifg", lst + 1, 12);
      chk("crc9 busy in ifg", 32'(mon_q[lst+11][10]), 32'd1);
      chk("crc9 busy after ifg", 32'(mon_q[lst+12][10]), 32'd0);
      chk("crc9 busy idle", 32'(busy), 32'd0);

      // Two 64-byte frames, tx_valid continuous
      for (int k = 0; k < 64; k++) begin
         pay[0][k] = 8'(k * 3 + 1);
         pay[1][k] = 8'(k) ^ 8'hA5;
      end
      mk = mon_q.size();
      r0 = rdy_count;
      send(0, 64, -1, -1);
      send(1, 64, -1, -1);
      idle_inputs();
      repeat (60) @(posedge clock);
      check_frame("b2b1", 0, 64, -1, 1'b0, 32'h0, mk, st, lst);
      check_frame("b2b2", 1, 64, -1, 1'b0, 32'h0, lst + 1, st2, lst2);
      chk("b2b gap", 32'(st2 - lst - 1), 32'd13);
      chk("b2b ready cycles", 32'(rdy_count - r0), 32'd128);
      chk("b2b ready after", 32'(tx_ready), 32'd0);

      // Underrun after 20 bytes of a 30-byte frame
      for (int k = 0; k < 30; k++) pay[0][k] = 8'h10 + 8'(k);
      mk = mon_q.size();
      u0 = ur_count;
      r0 = rdy_count;
      send(0, 30, 20, -1);
      idle_inputs();
      repeat (40) @(posedge clock);
      check_frame("urun", 0, 30, 20, 1'b0, 32'h0, mk, st, lst);
      check_idle("urun ifg", lst + 1, 12);
      chk("urun pulses", 32'(ur_count - u0), 32'd1);
      chk("urun ready cycles", 32'(rdy_count - r0), 32'd31);
      for (int k = 0; k < 9; k++) pay[0][k] = 8'h31 + 8'(k);
      mk = mon_q.size();
      send(0, 9, -1, -1);
      idle_inputs();
      repeat (100) @(posedge clock);
      check_frame("urun next", 0, 9, -1, !PAD_ON, 32'hCBF43926, mk, st, lst);
      check_idle("urun next ifg", lst + 1, 12);

      // Async reset during DATA byte 5
      for (int k = 0; k < 20; k++) pay[0][k] = 8'hC0 + 8'(k);
      send(0, 20, -1, 5);
      chk("pre-rst txd", 32'(txd_ddr), 32'hC4);
      chk("pre-rst ctl", 32'(tx_ctl_ddr), 32'd3);
      chk("pre-rst busy", 32'(busy), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid-rst txd", 32'(txd_ddr), 32'd0);
      chk("mid-rst ctl", 32'(tx_ctl_ddr), 32'd0);
      chk("mid-rst ready", 32'(tx_ready), 32'd0);
      chk("mid-rst busy", 32'(busy), 32'd0);
      tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      for (int k = 0; k < 9; k++) pay[0][k] = 8'h31 + 8'(k);
      mk = mon_q.size();
      send(0, 9, -1, -1);
      idle_inputs();
      repeat (100) @(posedge clock);
      check_frame("post-rst", 0, 9, -1, !PAD_ON, 32'hCBF43926, mk, st, lst);

      // Single-byte frame "a": FCS 0xE8B7BE43 (pad off)
      pay[0][0] = 8'h61;
      mk = mon_q.size();
      send(0, 1, -1, -1);
      idle_inputs();
      repeat (100) @(posedge clock);
      check_frame("one", 0, 1, -1, !PAD_ON, 32'hE8B7BE43, mk, st, lst);
      check_idle("one ifg", lst + 1, 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
